// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed multiply/divide sequencer for the execute stage.
// Latches operands on a mult/div start pulse, runs WIDTH shift-add or
// restoring-divide iterations on a shared accumulator, then emits one
// writeback beat with result, destination and exception status.
// Optional feature macro: MULTDIV_EXC_EN (exception/exc_code reporting).
// Ports:
//   i_clock, i_reset        rising-edge clock, async active-high reset
//   i_ctrl_mult, i_ctrl_div one-cycle start pulses (mult has priority)
//   i_data_a, i_data_b      operands (two's complement)
//   i_rd_in                 destination register of the issuing op
//   o_stall                 pipeline freeze (combinational)
//   o_result_ready          one-cycle writeback beat
//   o_result, o_result_rd   result and destination, held until next beat
//   o_exception, o_exc_code exception flag and rstatus code
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ctrl_mult,
  input  logic             i_ctrl_div,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic [4:0]       i_rd_in,
  output logic             o_stall,
  output logic             o_result_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [4:0]       o_result_rd,
  output logic             o_exception,
  output logic [WIDTH-1:0] o_exc_code
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic             r_neg;
  logic             r_is_div;
  logic [4:0]       r_rd;
  logic             r_result_ready;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_result_rd;

  logic             w_start;
  logic             w_div_zero;
  logic             w_last;
  logic             w_load;
  logic             w_finish;
  logic             w_zero_fin;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_mult_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_rem_ok;
  logic [AW-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_res_mag;
  logic [WIDTH-1:0] w_result;

  assign w_start    = i_ctrl_mult | i_ctrl_div;
  assign w_div_zero = ~i_ctrl_mult & i_ctrl_div & (i_data_b == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_abs_a    = i_data_a[WIDTH-1] ? -i_data_a : i_data_a;
  assign w_abs_b    = i_data_b[WIDTH-1] ? -i_data_b : i_data_b;

  // Multiply step: add multiplicand into the high half when the LSB is set, shift right.
  assign w_mult_sum = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  // Divide step: shift remainder/dividend left, trial-subtract the divisor.
  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign w_rem_sh   = {r_acc[AW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_mag_b};
  assign w_rem_ok   = ~w_rem_diff[WIDTH];

  assign w_acc_nxt = r_is_div
    ? {(w_rem_ok ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_rem_ok}
    : {w_mult_sum, r_acc[WIDTH-1:1]};

  // Low word holds the product low half or the quotient once the last step lands.
  assign w_res_mag = w_acc_nxt[WIDTH-1:0];

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode; stall is gated by reset so it drops immediately.
  always_comb begin
    o_stall    = 1'b0;
    w_load     = 1'b0;
    w_finish   = 1'b0;
    w_zero_fin = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall    = w_start;
        w_load     = w_start & ~w_div_zero;
        w_zero_fin = w_start & w_div_zero;
      end
      S_RUN: begin
        o_stall  = 1'b1;
        w_finish = w_last;
      end
      default: ;
    endcase
    if (i_reset) o_stall = 1'b0;
  end

  // Operand latch and iteration datapath
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_is_div <= 1'b0;
      r_rd     <= '0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_mag_a  <= w_abs_a;
      r_mag_b  <= w_abs_b;
      r_neg    <= i_data_a[WIDTH-1] ^ i_data_b[WIDTH-1];
      r_is_div <= ~i_ctrl_mult;
      r_rd     <= i_rd_in;
      r_acc    <= i_ctrl_mult ? {{WIDTH{1'b0}}, w_abs_b} : {{WIDTH{1'b0}}, w_abs_a};
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
    end
  end

  // Writeback beat registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_result_ready <= 1'b0;
      r_result       <= '0;
      r_result_rd    <= '0;
    end else begin
      r_result_ready <= w_finish | w_zero_fin;
      if (w_finish) begin
        r_result    <= w_result;
        r_result_rd <= r_rd;
      end else if (w_zero_fin) begin
        r_result    <= '0;
        r_result_rd <= i_rd_in;
      end
    end
  end

  assign o_result_ready = r_result_ready;
  assign o_result       = r_result;
  assign o_result_rd    = r_result_rd;

`ifdef MULTDIV_EXC_EN
  logic [AW-1:0]    w_wide;
  logic [AW-1:0]    w_wide_s;
  logic             w_ovf;
  logic             r_exception;
  logic [WIDTH-1:0] r_exc_code;

  // Signed full-width result; overflow when the high word is not the sign extension of the low.
  assign w_wide   = {(r_is_div ? {WIDTH{1'b0}} : w_acc_nxt[AW-1:WIDTH]), w_res_mag};
  assign w_wide_s = r_neg ? -w_wide : w_wide;
  assign w_ovf    = (w_wide_s[AW-1:WIDTH] != {WIDTH{w_wide_s[WIDTH-1]}});
  assign w_result = w_wide_s[WIDTH-1:0];

  // Exception status registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_exception <= 1'b0;
      r_exc_code  <= '0;
    end else if (w_finish) begin
      r_exception <= w_ovf;
      r_exc_code  <= w_ovf ? (r_is_div ? WIDTH'(5) : WIDTH'(4)) : '0;
    end else if (w_zero_fin) begin
      r_exception <= 1'b1;
      r_exc_code  <= WIDTH'(5);
    end
  end

  assign o_exception = r_exception;
  assign o_exc_code  = r_exc_code;
`else
  assign w_result    = r_neg ? -w_res_mag : w_res_mag;
  assign o_exception = 1'b0;
  assign o_exc_code  = '0;
`endif

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: self-checking bench for multdiv_seq (WIDTH = 32).
// A cycle-level behavioural model computes each beat with 64-bit signed
// arithmetic; a negedge process compares every output every cycle.
module tb_multdiv_seq;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          cm;
  logic          cd;
  logic [W-1:0]  da;
  logic [W-1:0]  db;
  logic [4:0]    rdi;
  logic          o_stall;
  logic          o_result_ready;
  logic [W-1:0]  o_result;
  logic [4:0]    o_result_rd;
  logic          o_exception;
  logic [W-1:0]  o_exc_code;

  int checks = 0;
  int errors = 0;

  multdiv_seq #(.WIDTH(W)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_ctrl_mult   (cm),
    .i_ctrl_div    (cd),
    .i_data_a      (da),
    .i_data_b      (db),
    .i_rd_in       (rdi),
    .o_stall       (o_stall),
    .o_result_ready(o_result_ready),
    .o_result      (o_result),
    .o_result_rd   (o_result_rd),
    .o_exception   (o_exception),
    .o_exc_code    (o_exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference result: {exception, exc_code, result} from plain signed arithmetic.
  function automatic logic [64:0] ref_op(input bit dv, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [31:0] res;
    logic e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!dv)          r = sa * sb;
    else if (b == 0)  r = 0;
    else              r = sa / sb;
    res = r[31:0];
    e = (dv && b == 0) || (r != longint'($signed(res)));
`ifndef MULTDIV_EXC_EN
    e = 1'b0;
`endif
    return {e, (e ? (dv ? 32'd5 : 32'd4) : 32'd0), res};
  endfunction

  // Behavioural model: idle / busy for W edges / one beat cycle.
  logic        m_busy, m_beat, m_exc;
  int          m_left;
  logic [31:0] m_res, m_code;
  logic [4:0]  m_rd, p_rd;
  logic [64:0] p_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_beat <= 1'b0; m_left <= 0;
      m_res <= '0; m_code <= '0; m_exc <= 1'b0; m_rd <= '0;
      p_out <= '0; p_rd <= '0;
    end else if (m_beat) begin
      m_beat <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_beat <= 1'b1;
        {m_exc, m_code, m_res} <= p_out;
        m_rd <= p_rd;
      end
    end else if (cm || cd) begin
      p_out <= ref_op(!cm, da, db);
      p_rd  <= rdi;
      if (!cm && db == 0) begin
        m_beat <= 1'b1;
        {m_exc, m_code, m_res} <= ref_op(1'b1, da, db);
        m_rd <= rdi;
      end else begin
        m_busy <= 1'b1;
        m_left <= W;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !rst && (m_busy || (!m_beat && (cm || cd)));
    chk("stall",     32'(o_stall),        32'(exp_stall));
    chk("ready",     32'(o_result_ready), 32'(m_beat));
    chk("result",    o_result,            m_res);
    chk("result_rd", 32'(o_result_rd),    32'(m_rd));
    chk("exception", 32'(o_exception),    32'(m_exc));
    chk("exc_code",  o_exc_code,          m_code);
  end

  // Issue one op, run ncyc further cycles, optionally pulse ctrl_div / reset.
  task automatic op(input bit dv, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                    input int ncyc, input int pulse1, input int pulse2, input int rst_at,
                    output int lat, output int nready, output logic [31:0] res,
                    output logic [4:0] rrd, output logic exc, output logic [31:0] code);
    @(posedge clk); #1;
    cm = !dv; cd = dv; da = a; db = b; rdi = rd;
    lat = -1; nready = 0; res = '0; rrd = '0; exc = 1'b0; code = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      cm = 1'b0;
      cd = (c == pulse1) || (c == pulse2);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_ready", 32'(o_result_ready), 32'd0);
        chk("rst_exc",   32'(o_exception), 32'd0);
        #1 rst = 1'b0;
      end
      @(negedge clk);
      if (o_result_ready) begin
        nready++;
        if (lat < 0) begin
          lat = c; res = o_result; rrd = o_result_rd; exc = o_exception; code = o_exc_code;
        end
      end
    end
    cd = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  int          lat, nr;
  logic [31:0] res, code;
  logic [4:0]  rrd;
  logic        exc;
  bit          exc_on;

  initial begin
`ifdef MULTDIV_EXC_EN
    exc_on = 1'b1;
`else
    exc_on = 1'b0;
`endif
    rst = 1'b1; cm = 1'b0; cd = 1'b0; da = '0; db = '0; rdi = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", o_result, 32'd0);
    chk("reset_ready",  32'(o_result_ready), 32'd0);
    rst = 1'b0;

    op(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd9, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_res", res, 32'hFFFF_FFD6);
    chk("mul_rd",  32'(rrd), 32'd9);
    chk("mul_exc", 32'(exc), 32'd0);

    op(1'b1, 32'd100, 32'hFFFF_FFF9, 5'd3, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("div1_lat", 32'(lat), 32'd33);
    chk("div1_res", res, 32'hFFFF_FFF2);
    chk("div1_exc", 32'(exc), 32'd0);

    op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd4, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("div2_res", res, 32'hFFFF_FFF2);

    op(1'b1, 32'd5, 32'd0, 5'd12, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("dz_lat",  32'(lat), 32'd1);
    chk("dz_res",  res, 32'd0);
    chk("dz_rd",   32'(rrd), 32'd12);
    chk("dz_exc",  32'(exc), exc_on ? 32'd1 : 32'd0);
    chk("dz_code", code, exc_on ? 32'd5 : 32'd0);

    op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("movf_res",  res, 32'd0);
    chk("movf_exc",  32'(exc), exc_on ? 32'd1 : 32'd0);
    chk("movf_code", code, exc_on ? 32'd4 : 32'd0);

    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("dovf_res",  res, 32'h8000_0000);
    chk("dovf_exc",  32'(exc), exc_on ? 32'd1 : 32'd0);
    chk("dovf_code", code, exc_on ? 32'd5 : 32'd0);

    // Starts during RUN and DONE must be ignored.
    op(1'b0, 32'd123, 32'd45, 5'd7, 40, 10, 33, -1, lat, nr, res, rrd, exc, code);
    chk("ign_nready", 32'(nr), 32'd1);
    chk("ign_lat",    32'(lat), 32'd33);
    chk("ign_res",    res, 32'd5535);

    // Reset mid-RUN discards the operation.
    op(1'b1, 32'd1000, 32'd3, 5'd5, 40, -1, -1, 15, lat, nr, res, rrd, exc, code);
    chk("rst_nready", 32'(nr), 32'd0);

    op(1'b0, 32'd3, 32'd3, 5'd8, 33, -1, -1, -1, lat, nr, res, rrd, exc, code);
    chk("post_lat", 32'(lat), 32'd33);
    chk("post_res", res, 32'd9);

    // Randomized back-to-back ops checked by the model.
    for (int i = 0; i < 120; i++) begin
      op(1'($urandom_range(0, 1)), rnd_val(), rnd_val(), 5'($urandom), 33, -1, -1, -1,
         lat, nr, res, rrd, exc, code);
      chk("rnd_nready", 32'(nr), 32'd1);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative signed multiply/divide sequencer for the execute stage. It latches operands and the destination register when the decoder flags a mult or div operation, then runs a shared shift-add / restoring-divide datapath for WIDTH iterations. While it runs, it holds the pipeline stall, then presents one writeback beat carrying the result, destination, and exception status.

## Interface
- WIDTH, 32: operand/result width; minimum 4; iteration count = WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ctrl_mult  in  1  one-cycle start pulse for multiply (decoded ALU op 00110)
- ctrl_div  in  1  one-cycle start pulse for divide (decoded ALU op 00111)
- data_a  in  WIDTH  operand A / dividend, two's complement
- data_b  in  WIDTH  operand B / divisor, two's complement
- rd_in  in  5  destination register of the issuing instruction
- stall  out  1  freeze fetch/decode/execute
- result_ready  out  1  one-cycle writeback beat
- result  out  WIDTH  product low word or quotient
- result_rd  out  5  destination register for the beat
- exception  out  1  overflow / divide-by-zero flag, valid with result_ready
- exc_code  out  WIDTH  rstatus value, valid with result_ready

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with all outputs 0.
- IDLE: ctrl_mult or ctrl_div latches |a|, |b|, the signs, rd_in, and the op, clears the counter, and moves to RUN.
  - ctrl_mult has priority if both are high.
  - A divide with data_b == 0 goes directly to DONE.
- RUN:
  - One iteration per cycle.
  - Counter counts 0..WIDTH-1; on WIDTH-1 the block moves to DONE.
  - Multiply: shift-add into a 2*WIDTH magnitude accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit magnitude quotient.
  - Starts are ignored.
- DONE:
  - result_ready = 1 for exactly one cycle, then IDLE.
  - Starts are ignored in this cycle.
  - result, result_rd, exception, and exc_code hold their values until the next DONE.
- Sign rules:
  - Product and quotient sign = sign(a) XOR sign(b); negation is applied after the magnitude result.
  - Quotient truncates toward zero; the remainder is discarded.
- Multiply result = low WIDTH bits of the signed 2*WIDTH product.
  - Overflow when the upper WIDTH bits are not the sign extension of the low word.
- Divide by zero: result = 0.
- Divide of the most negative value by -1: result = most negative value; flagged as overflow.
- stall = (IDLE & (ctrl_mult | ctrl_div)) | RUN. stall is 0 in DONE so the writeback beat advances.

## Timing
- A start sampled at edge 0 gives RUN on edges 1..WIDTH and DONE/result_ready during the cycle after edge WIDTH. Multiply/divide latency = WIDTH+1 cycles; stall is high for WIDTH+1 cycles.
- Divide by zero: result_ready in the cycle after the start edge.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE, at the earliest.
- Asynchronous reset at any point, including mid-RUN, returns the block to IDLE immediately.
  - stall, result_ready, and exception drop to 0 combinationally with reset.
  - The partial result is discarded and no beat is emitted.
- All outputs are registered except stall.

## Configuration
- MULTDIV_EXC_EN defined:
  - exception = 1 on multiply overflow, divide by zero, or divide overflow.
  - exc_code = 4 for multiply, 5 for divide; 0 when exception = 0.
- MULTDIV_EXC_EN undefined:
  - exception and exc_code are tied to 0.
  - Result values are unchanged, including 0 on divide by zero.
  - The overflow-detect logic is not built.

## Test plan
- Multiply 7 × -6 (0xFFFFFFFA) → result_ready at cycle 33; result 0xFFFFFFD6; result_rd echoes rd_in = 9; exception 0; stall high cycles 0..32.
- Divide 100 ÷ -7 → result 0xFFFFFFF2 (-14) after 33 cycles; -100 ÷ 7 → 0xFFFFFFF2; exception 0.
- Divide 5 ÷ 0 → result_ready at cycle 1; result 0.
  - With MULTDIV_EXC_EN: exception 1, exc_code 5.
  - Without MULTDIV_EXC_EN: exception 0.
- Multiply 0x00010000 × 0x00010000 → result 0x00000000.
  - With MULTDIV_EXC_EN: exception 1, exc_code 4.
  - Also check 0x80000000 ÷ 0xFFFFFFFF → result 0x80000000, exception 1.
- Pulse ctrl_div at RUN cycle 10 and in the DONE cycle → ignored. Exactly one result_ready occurs, and the first operation's result is unchanged.
- Assert reset at RUN cycle 15 → stall 0 and state IDLE immediately; no result_ready follows. A subsequent 3 × 3 produces 9 at cycle 33.
